counter_down_reload: RTL
========================

Name: counter_down_reload

Overview:
Synchronous down counter with parallel load, reload register and a small run-control FSM: the count-down counterpart of the team's load-capable up counters. It serves as a programmable interval/timeout source. Modes are one-shot, periodic auto-reload, and free-running wrap. It raises a terminal-count flag and a one-cycle done pulse for downstream control logic.

Parameters:
WIDTH, 3, counter and reload register width in bits (min 2).
RELOAD_DEF, {WIDTH{1'b1}}, reload register value after reset.

Ports:
clk  input  1  rising-edge clock.
reset_al_in  input  1  asynchronous, active-low reset.
d_in  input  WIDTH  parallel load value for both the counter and the reload register.
load_in  input  1  synchronous load strobe.
start_in  input  1  start or resume counting.
stop_in  input  1  pause counting and hold the count.
mode_in  input  2  00 one-shot, 01 periodic reload, 10 free-wrap, 11 treated as 00.
q_out  output  WIDTH  current count, registered.
tc_out  output  1  terminal count: high while state==RUN and q_out==0 (combinational decode of registers).
busy_out  output  1  high while state==RUN.
done_out  output  1  registered one-cycle pulse when one-shot completes.

Behaviour:
- Reset (async, while reset_al_in=0):
  - q_out=0, reload_r=RELOAD_DEF, state=IDLE.
  - tc_out=0, busy_out=0, done_out=0.
  - Release is synchronous to the next clk edge. Reset mid-count aborts immediately with no done pulse.
- States: IDLE, RUN, DONE.
- Per-edge priority: load_in > stop_in > start_in > count.
- load_in (any state):
  - q_out<=d_in, reload_r<=d_in, state<=IDLE.
  - start_in/stop_in ignored that cycle.
- stop_in:
  - In RUN: state<=IDLE, q_out held.
  - In IDLE/DONE: no effect.
- start_in:
  - In IDLE: state<=RUN, q_out unchanged (resume from current value).
  - In DONE: q_out<=reload_r, state<=RUN.
  - In RUN: ignored.
- RUN, each edge with no higher-priority event:
  - q_out!=0: q_out<=q_out-1 (WIDTH-bit arithmetic).
  - q_out==0 and mode 00/11: q_out stays 0, state<=DONE, done_out<=1 for exactly one cycle.
  - q_out==0 and mode 01: q_out<=reload_r, stay RUN.
  - q_out==0 and mode 10: q_out<={WIDTH{1'b1}} (natural wrap), stay RUN.
- Timing:
  - The start edge enters RUN without decrementing.
  - Loaded value N is visible for one RUN cycle, then N-1 … 0.
  - tc_out is high for the single cycle q_out==0 in RUN.
  - Periodic period = reload_r+1 cycles.
  - N=0 with start: tc_out high in the first RUN cycle.
- mode_in is sampled at each edge; a change takes effect at the next terminal event.
- done_out is 0 in every cycle other than the cycle after the RUN->DONE transition.
- Simultaneous load_in and terminal event: load wins, no done pulse, tc_out drops with the state change.

Decomposition:
- Shared include file counter_defs.vh holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - mode encodings: ONE_SHOT, PERIODIC, FREE_WRAP.
- One sub-module: counter_down_core, the WIDTH-bit datapath register.
  - Inputs: ld, ld_val, dec.
  - Outputs: q and zero flag.
- The FSM, reload register and outputs stay in the top.

Test Plan:
1. Reset mid-run (q=3, RUN), pulse reset_al_in low -> q_out=0, busy/tc/done=0 asynchronously; after release, reload_r=7 (WIDTH=3).
2. One-shot: load d_in=5, start -> q_out 5,4,3,2,1,0; tc_out high one cycle at 0; done_out one pulse; state DONE, busy_out=0, q_out holds 0.
3. Periodic: load 2, mode 01, start -> q_out 2,1,0,2,1,0…; tc_out every 3rd cycle; done_out never asserts.
4. Free-wrap: load 1, mode 10 -> 1,0,7,6,…,0,7; tc_out each time q_out=0.
5. Pause/resume and priority:
   - Load 6, start, stop at q=4 -> q_out holds 4, busy_out=0; start -> resumes 4,3,…
   - load_in with stop_in/start_in same edge -> load wins, IDLE.
6. DONE restart and collision:
   - From DONE, start -> q_out=reload_r (5), counts again.
   - load_in on the terminal edge -> q_out=d_in, no done pulse.

Source files
------------

// File: rtl/counter_down_reload_pkg.sv
// Shared encodings for the reloadable down counter: run-control states and
// counting modes, plus the mode_in decode (the reserved code 11 acts as one-shot).
package counter_down_reload_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      MODE_ONE_SHOT  = 2'b00,
      MODE_PERIODIC  = 2'b01,
      MODE_FREE_WRAP = 2'b10
   } mode_t;

   function automatic mode_t decode_mode(input logic [1:0] mode_raw);
      mode_t m;
      case (mode_raw)
         2'b01:   m = MODE_PERIODIC;
         2'b10:   m = MODE_FREE_WRAP;
         default: m = MODE_ONE_SHOT;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/counter_down_reload_core.sv
// Down-counting datapath register: parallel load has priority over decrement.
// Decrementing from zero wraps naturally to all ones.
module counter_down_core #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset_al_in,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] q,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // count register: load, else decrement, else hold
   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in)
         q <= '0;
      else if (ld)
         q <= ld_val;
      else if (dec)
         q <= q - ONE;
   end

   assign zero = (q == '0);

endmodule

// File: rtl/counter_down_reload.sv
// Programmable interval / timeout source: down counter with reload register,
// one-shot / periodic / free-wrap modes, terminal-count flag and done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | stopped, count held; start resumes from the current value
// ST_RUN  | counting down one per clk; terminal action taken at zero
// ST_DONE | one-shot finished, count held at 0; start reloads and runs
module counter_down_reload
   import counter_down_reload_pkg::*;
#(
   parameter int               WIDTH      = 3,
   parameter logic [WIDTH-1:0] RELOAD_DEF = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_al_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic             load_in,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic [1:0]       mode_in,
   output logic [WIDTH-1:0] q_out,
   output logic             tc_out,
   output logic             busy_out,
   output logic             done_out
);

   state_t           state;
   logic [WIDTH-1:0] reload_r;
   mode_t            mode;
   logic             zero;
   logic             stop_run;
   logic             start_evt;
   logic             run_evt;
   logic             core_ld;
   logic             core_dec;
   logic [WIDTH-1:0] core_ld_val;

   assign mode = decode_mode(mode_in);

   // stop only matters while running; start only acts from IDLE or DONE
   assign stop_run  = !load_in && stop_in && (state == ST_RUN);
   assign start_evt = !load_in && !stop_run && start_in && (state != ST_RUN);
   assign run_evt   = !load_in && !stop_run && (state == ST_RUN);

   // datapath control: restart from DONE and periodic terminal both reload
   always_comb begin
      core_ld     = 1'b0;
      core_dec    = 1'b0;
      core_ld_val = reload_r;
      if (load_in) begin
         core_ld     = 1'b1;
         core_ld_val = d_in;
      end else if (start_evt && (state == ST_DONE)) begin
         core_ld = 1'b1;
      end else if (run_evt) begin
         if (!zero || (mode == MODE_FREE_WRAP))
            core_dec = 1'b1;
         else if (mode == MODE_PERIODIC)
            core_ld = 1'b1;
      end
   end

   counter_down_core #(.WIDTH(WIDTH)) u_core (
      .clk         (clk),
      .reset_al_in (reset_al_in),
      .ld          (core_ld),
      .ld_val      (core_ld_val),
      .dec         (core_dec),
      .q           (q_out),
      .zero        (zero)
   );

   // run-control FSM, reload register and the registered done pulse
   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state    <= ST_IDLE;
         reload_r <= RELOAD_DEF;
         done_out <= 1'b0;
      end else begin
         done_out <= 1'b0;
         if (load_in) begin
            reload_r <= d_in;
            state    <= ST_IDLE;
         end else if (stop_run) begin
            state <= ST_IDLE;
         end else if (start_evt) begin
            state <= ST_RUN;
         end else if (run_evt && zero && (mode == MODE_ONE_SHOT)) begin
            state    <= ST_DONE;
            done_out <= 1'b1;
         end
      end
   end

   assign busy_out = (state == ST_RUN);
   assign tc_out   = busy_out && zero;

endmodule
